// File: rtl/vpu_vram_arb.sv
// Port-A arbiter for the four VPU RAMs: round-robin between CPU and DMA,
// flat-address decode, one-cycle registered issue and a 2-stage read-return tag.
module vpu_vram_arb #(
    parameter int DATA_W      = 32,
    parameter int SP_ADDR_W   = 8,
    parameter int MAP_ADDR_W  = 12,
    parameter int TILE_ADDR_W = 13,
    parameter int PAL_ADDR_W  = 9
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [15:0]            cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    output logic                   cpu_gnt,
    output logic                   cpu_rvalid,
    output logic [DATA_W-1:0]      cpu_rdata,
    output logic                   cpu_err,

    input  logic                   dma_req,
    input  logic                   dma_we,
    input  logic [15:0]            dma_addr,
    input  logic [DATA_W-1:0]      dma_wdata,
    output logic                   dma_gnt,
    output logic                   dma_rvalid,
    output logic [DATA_W-1:0]      dma_rdata,
    output logic                   dma_err,

    output logic                   sp_en,
    output logic                   sp_we,
    output logic [SP_ADDR_W-1:0]   sp_addr,
    output logic [DATA_W-1:0]      sp_din,
    input  logic [DATA_W-1:0]      sp_dout,

    output logic                   map_en,
    output logic                   map_we,
    output logic [MAP_ADDR_W-1:0]  map_addr,
    output logic [DATA_W-1:0]      map_din,
    input  logic [DATA_W-1:0]      map_dout,

    output logic                   tile_en,
    output logic                   tile_we,
    output logic [TILE_ADDR_W-1:0] tile_addr,
    output logic [DATA_W-1:0]      tile_din,
    input  logic [DATA_W-1:0]      tile_dout,

    output logic                   pal_en,
    output logic                   pal_we,
    output logic [PAL_ADDR_W-1:0]  pal_addr,
    output logic [DATA_W-1:0]      pal_din,
    input  logic [DATA_W-1:0]      pal_dout
);

    localparam logic [1:0] REG_SP   = 2'd0;
    localparam logic [1:0] REG_MAP  = 2'd1;
    localparam logic [1:0] REG_TILE = 2'd2;
    localparam logic [1:0] REG_PAL  = 2'd3;

    logic              last_cpu;
    logic              xfer;
    logic              sel_we;
    logic [15:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [1:0]        region;
    logic [13:0]       offset;
    logic              dec_err;
    logic              issue;

    logic              t1_valid, t1_dma, t1_err;
    logic [1:0]        t1_region;
    logic              t2_valid, t2_dma, t2_err;
    logic [1:0]        t2_region;

    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] ret_data;
    logic [DATA_W-1:0] cpu_hold;
    logic [DATA_W-1:0] dma_hold;

    // last_cpu=1 means the CPU won the most recent transfer, so DMA wins a tie.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (cpu_req && dma_req) begin
            cpu_gnt = ~last_cpu;
            dma_gnt = last_cpu;
        end else begin
            cpu_gnt = cpu_req;
            dma_gnt = dma_req;
        end
    end

    always_comb begin
        xfer      = cpu_gnt | dma_gnt;
        sel_we    = dma_gnt ? dma_we    : cpu_we;
        sel_addr  = dma_gnt ? dma_addr  : cpu_addr;
        sel_wdata = dma_gnt ? dma_wdata : cpu_wdata;
        region    = sel_addr[15:14];
        offset    = sel_addr[13:0];
    end

    always_comb begin
        dec_err = 1'b0;
        case (region)
            REG_SP:   dec_err = |(offset >> SP_ADDR_W);
            REG_MAP:  dec_err = |(offset >> MAP_ADDR_W);
            REG_TILE: dec_err = |(offset >> TILE_ADDR_W);
            default:  dec_err = |(offset >> PAL_ADDR_W);
        endcase
        issue = xfer & ~dec_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_cpu <= 1'b1;
        else if (xfer)
            last_cpu <= cpu_gnt;
    end

    // Address/data registers only load when their RAM is enabled; they are don't-care otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_en     <= 1'b0;
            sp_we     <= 1'b0;
            sp_addr   <= '0;
            sp_din    <= '0;
            map_en    <= 1'b0;
            map_we    <= 1'b0;
            map_addr  <= '0;
            map_din   <= '0;
            tile_en   <= 1'b0;
            tile_we   <= 1'b0;
            tile_addr <= '0;
            tile_din  <= '0;
            pal_en    <= 1'b0;
            pal_we    <= 1'b0;
            pal_addr  <= '0;
            pal_din   <= '0;
        end else begin
            sp_en   <= issue && (region == REG_SP);
            sp_we   <= issue && (region == REG_SP) && sel_we;
            map_en  <= issue && (region == REG_MAP);
            map_we  <= issue && (region == REG_MAP) && sel_we;
            tile_en <= issue && (region == REG_TILE);
            tile_we <= issue && (region == REG_TILE) && sel_we;
            pal_en  <= issue && (region == REG_PAL);
            pal_we  <= issue && (region == REG_PAL) && sel_we;
            if (issue && (region == REG_SP)) begin
                sp_addr <= offset[SP_ADDR_W-1:0];
                sp_din  <= sel_wdata;
            end
            if (issue && (region == REG_MAP)) begin
                map_addr <= offset[MAP_ADDR_W-1:0];
                map_din  <= sel_wdata;
            end
            if (issue && (region == REG_TILE)) begin
                tile_addr <= offset[TILE_ADDR_W-1:0];
                tile_din  <= sel_wdata;
            end
            if (issue && (region == REG_PAL)) begin
                pal_addr <= offset[PAL_ADDR_W-1:0];
                pal_din  <= sel_wdata;
            end
        end
    end

    // Read tag follows the transfer through issue (t1) to RAM output (t2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t1_valid  <= 1'b0;
            t1_dma    <= 1'b0;
            t1_err    <= 1'b0;
            t1_region <= '0;
            t2_valid  <= 1'b0;
            t2_dma    <= 1'b0;
            t2_err    <= 1'b0;
            t2_region <= '0;
        end else begin
            t1_valid  <= xfer & ~sel_we;
            t1_dma    <= dma_gnt;
            t1_err    <= dec_err;
            t1_region <= region;
            t2_valid  <= t1_valid;
            t2_dma    <= t1_dma;
            t2_err    <= t1_err;
            t2_region <= t1_region;
        end
    end

    always_comb begin
        ram_dout = '0;
        case (t2_region)
            REG_SP:   ram_dout = sp_dout;
            REG_MAP:  ram_dout = map_dout;
            REG_TILE: ram_dout = tile_dout;
            default:  ram_dout = pal_dout;
        endcase
        ret_data   = t2_err ? '0 : ram_dout;
        cpu_rvalid = t2_valid & ~t2_dma;
        dma_rvalid = t2_valid & t2_dma;
        cpu_err    = cpu_rvalid & t2_err;
        dma_err    = dma_rvalid & t2_err;
        cpu_rdata  = cpu_rvalid ? ret_data : cpu_hold;
        dma_rdata  = dma_rvalid ? ret_data : dma_hold;
    end

    // RAM dout arrives combinationally in T+2; the hold registers keep rdata stable afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_hold <= '0;
            dma_hold <= '0;
        end else begin
            cpu_hold <= cpu_rdata;
            dma_hold <= dma_rdata;
        end
    end

endmodule
